// File: rtl/rv32i_bus_pkg.sv
// Shared definitions for the RV32I data-memory bus slice.
// Contents:
//   - Router FSM state encoding (IDLE/REQ/RESP/ERR).
//   - Bus geometry: number of targets, region-select width, data/address/mask widths.
//   - sel_onehot(): converts a region select into a one-hot target vector.
package rv32i_bus_pkg;

  localparam int NUM_TGT = 8;
  localparam int SEL_W   = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } router_state_t;

  function automatic logic [NUM_TGT-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_TGT-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_router_1to8_if.sv
// Bundle of all request/response signals of the 1-to-8 data-memory router.
//
// Handshake semantics (applies to both the up_* and tgt_* request channels):
//   A request transfers on a rising clock edge where valid and ready are both
//   high. Once valid is raised it stays high, with its payload held stable,
//   until that transfer edge. Ready may change freely and never depends on
//   valid. Responses (rsp_valid, tgt_rvalid) are pulses with no back-pressure.
//
// Modports:
//   slave  - the router: accepts up_* requests, drives tgt_* requests,
//            receives tgt_r* responses, drives rsp_*.
//   master - the environment (core plus targets), mirror image of slave.
interface dmem_router_1to8_if;
  import rv32i_bus_pkg::*;

  // core-facing request / response
  logic                      up_valid;
  logic                      up_ready;
  logic [ADDR_W-1:0]         up_addr;
  logic                      up_we;
  logic [DATA_W-1:0]         up_wdata;
  logic [MASK_W-1:0]         up_wmask;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  // target-facing request / response
  logic [NUM_TGT-1:0]        tgt_valid;
  logic [NUM_TGT-1:0]        tgt_ready;
  logic [ADDR_W-1:0]         tgt_addr;
  logic                      tgt_we;
  logic [DATA_W-1:0]         tgt_wdata;
  logic [MASK_W-1:0]         tgt_wmask;
  logic [NUM_TGT-1:0]        tgt_rvalid;
  logic [NUM_TGT*DATA_W-1:0] tgt_rdata;

  modport slave (
    input  up_valid, up_addr, up_we, up_wdata, up_wmask,
    input  tgt_ready, tgt_rvalid, tgt_rdata,
    output up_ready, rsp_valid, rsp_rdata, rsp_err,
    output tgt_valid, tgt_addr, tgt_we, tgt_wdata, tgt_wmask
  );

  modport master (
    output up_valid, up_addr, up_we, up_wdata, up_wmask,
    output tgt_ready, tgt_rvalid, tgt_rdata,
    input  up_ready, rsp_valid, rsp_rdata, rsp_err,
    input  tgt_valid, tgt_addr, tgt_we, tgt_wdata, tgt_wmask
  );

endinterface

// File: rtl/dmem_router_1to8_rsp_select.sv
// dmem_rsp_select: combinational 8:1 selection of one target's response.
// Ports:
//   sel        in  region select of the outstanding transaction
//   tgt_rvalid in  per-target response valid
//   tgt_rdata  in  flattened per-target read data, target i at [32*i+31:32*i]
//   rvalid     out response valid of the selected target
//   rdata      out read data of the selected target
module dmem_rsp_select
  import rv32i_bus_pkg::*;
(
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_TGT-1:0]        tgt_rvalid,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         rdata
);

  always_comb begin
    rvalid = tgt_rvalid[sel];
    rdata  = tgt_rdata[int'(sel)*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/dmem_router_1to8.sv
// dmem_router_1to8: routes one data-memory request from the MEM stage to one
// of eight targets, selected by addr[SEL_LSB+2:SEL_LSB], and returns that
// target's response. One transaction is outstanding at a time.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   bus        slave modport of dmem_router_1to8_if (up_*, rsp_*, tgt_*)
//   dbg_state  out  current FSM state, for observation only
//
// Parameters:
//   SEL_LSB         bit position of the 3-bit region select
//   MAP_MASK        bit i set = target i populated; others answer with rsp_err
//   TIMEOUT_CYCLES  response-wait limit (1..255), used with ROUTER_TIMEOUT_EN
//
// Optional feature (macro ROUTER_TIMEOUT_EN): an 8-bit counter bounds the
// RESP wait; on expiry the transaction ends with rsp_err. Without the macro
// RESP waits indefinitely and no counter exists.
module dmem_router_1to8
  import rv32i_bus_pkg::*;
#(
  parameter int             SEL_LSB        = 29,
  parameter logic [NUM_TGT-1:0] MAP_MASK   = 8'hFF,
  parameter int             TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  dmem_router_1to8_if.slave bus,
  output router_state_t dbg_state
);

  // Elaboration-time sanity checks on the configuration.
  if (SEL_LSB < 0 || SEL_LSB > ADDR_W - SEL_W) begin : g_bad_sel_lsb
    $error("SEL_LSB out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  router_state_t      state;
  logic [SEL_W-1:0]   sel_q;
  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_we;
  logic [DATA_W-1:0]  cap_wdata;
  logic [MASK_W-1:0]  cap_wmask;
  logic [NUM_TGT-1:0] tgt_valid_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic [SEL_W-1:0]   up_sel;
  logic               sel_rvalid;
  logic [DATA_W-1:0]  sel_rdata;

`ifdef ROUTER_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  assign wait_cnt_nxt = wait_cnt + 8'd1;
`endif

  assign up_sel = bus.up_addr[SEL_LSB +: SEL_W];

  // Only the outstanding target's response is ever looked at; the selector
  // is driven by the captured sel, so stray rvalids elsewhere are invisible.
  dmem_rsp_select u_rsp_select (
    .sel        (sel_q),
    .tgt_rvalid (bus.tgt_rvalid),
    .tgt_rdata  (bus.tgt_rdata),
    .rvalid     (sel_rvalid),
    .rdata      (sel_rdata)
  );

  always_ff @(posedge clk) begin
    // rsp_valid is a one-cycle pulse: cleared every cycle unless set below.
    rsp_valid_q <= 1'b0;
    if (rst) begin
      state       <= IDLE;
      sel_q       <= '0;
      cap_addr    <= '0;
      cap_we      <= 1'b0;
      cap_wdata   <= '0;
      cap_wmask   <= '0;
      tgt_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef ROUTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // up_ready is (state == IDLE), so up_valid alone is the accept.
          if (bus.up_valid) begin
            cap_addr  <= bus.up_addr;
            cap_we    <= bus.up_we;
            cap_wdata <= bus.up_wdata;
            cap_wmask <= bus.up_wmask;
            sel_q     <= up_sel;
            if (MAP_MASK[up_sel]) begin
              tgt_valid_q <= sel_onehot(up_sel);
              state       <= REQ;
            end else begin
              state <= ERR;
            end
          end
        end
        REQ: begin
          if (bus.tgt_ready[sel_q]) begin
            tgt_valid_q <= '0;
            state       <= RESP;
`ifdef ROUTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        RESP: begin
          if (sel_rvalid) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= cap_we ? '0 : sel_rdata;
            state       <= IDLE;
          end
`ifdef ROUTER_TIMEOUT_EN
          // Give up once the count of empty RESP cycles reaches the limit;
          // anything the target sends afterwards lands in IDLE and is dropped.
          else if (wait_cnt_nxt == 8'(TIMEOUT_CYCLES)) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt_nxt;
          end
`endif
        end
        ERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.up_ready  = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.tgt_valid = tgt_valid_q;
  assign bus.tgt_addr  = cap_addr;
  assign bus.tgt_we    = cap_we;
  assign bus.tgt_wdata = cap_wdata;
  assign bus.tgt_wmask = cap_wmask;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_router_1to8.sv
// Testbench for dmem_router_1to8. Two instances: u_dut (all targets mapped,
// TIMEOUT_CYCLES=4) carries most scenarios; u_dut_um (MAP_MASK=8'h7F) covers
// the unmapped region. Inputs are driven and outputs sampled on the falling
// edge. Expected responses are pushed to exp_q when a request is issued and
// popped when rsp_valid is seen.
module tb_dmem_router_1to8;
  import rv32i_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_router_1to8_if bus ();
  dmem_router_1to8_if bus_um ();
  router_state_t dbg_state;
  router_state_t dbg_state_um;

  dmem_router_1to8 #(.SEL_LSB(29), .MAP_MASK(8'hFF), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  dmem_router_1to8 #(.SEL_LSB(29), .MAP_MASK(8'h7F), .TIMEOUT_CYCLES(4)) u_dut_um (
    .clk(clk), .rst(rst), .bus(bus_um), .dbg_state(dbg_state_um)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs;
    bus.up_valid = 0; bus.up_addr = '0; bus.up_we = 0; bus.up_wdata = '0; bus.up_wmask = '0;
    bus.tgt_ready = '0; bus.tgt_rvalid = '0; bus.tgt_rdata = '0;
    bus_um.up_valid = 0; bus_um.up_addr = '0; bus_um.up_we = 0; bus_um.up_wdata = '0;
    bus_um.up_wmask = '0; bus_um.tgt_ready = '0; bus_um.tgt_rvalid = '0; bus_um.tgt_rdata = '0;
  endtask

  // Presents one request for one cycle; returns one cycle after acceptance.
  task automatic send_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic exp_err,
                          input logic [31:0] exp_rdata, input bit push);
    bus.up_valid = 1; bus.up_addr = addr; bus.up_we = we;
    bus.up_wdata = wdata; bus.up_wmask = wmask;
    if (push) exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    bus.up_valid = 0;
  endtask

  task automatic set_rdata(input int t, input logic [31:0] d);
    bus.tgt_rdata[t*32 +: 32] = d;
  endtask

  // Target t accepts after ready_dly cycles and answers rvalid_dly cycles later.
  task automatic serve(input int t, input int ready_dly, input int rvalid_dly,
                       input logic [31:0] d);
    repeat (ready_dly) @(negedge clk);
    bus.tgt_ready[t] = 1'b1;
    @(negedge clk);
    bus.tgt_ready = '0;
    repeat (rvalid_dly) @(negedge clk);
    bus.tgt_rvalid[t] = 1'b1;
    set_rdata(t, d);
    @(negedge clk);
    bus.tgt_rvalid = '0;
  endtask

  task automatic wait_rsp(output bit seen);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.up_ready !== 1'b1) begin n_bad++; $display("FAIL reset_up_ready got %b exp 1", bus.up_ready); end
    n_cmp++; if (bus.tgt_valid !== 8'h00) begin n_bad++; $display("FAIL reset_tgt_valid got %h exp 00", bus.tgt_valid); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
    n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
    n_cmp++; if (bus.tgt_addr !== 32'h0) begin n_bad++; $display("FAIL reset_tgt_addr got %h exp 0", bus.tgt_addr); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_read_t3;
    logic [32:0] got, exp;
    send_req(32'h6000_0010, 0, 32'h0, 4'hF, 0, 32'hCAFE_0003, 1);
    // N+1
    n_cmp++; if (bus.tgt_valid !== 8'h08) begin n_bad++; $display("FAIL rd3_tgt_valid got %h exp 08", bus.tgt_valid); end
    n_cmp++; if (bus.tgt_addr !== 32'h6000_0010) begin n_bad++; $display("FAIL rd3_tgt_addr got %h exp 60000010", bus.tgt_addr); end
    n_cmp++; if (bus.tgt_we !== 1'b0) begin n_bad++; $display("FAIL rd3_tgt_we got %b exp 0", bus.tgt_we); end
    n_cmp++; if (bus.up_ready !== 1'b0) begin n_bad++; $display("FAIL rd3_up_ready_busy got %b exp 0", bus.up_ready); end
    bus.tgt_ready = 8'h08;
    @(negedge clk);  // N+2
    bus.tgt_ready = '0;
    n_cmp++; if (bus.tgt_valid !== 8'h00) begin n_bad++; $display("FAIL rd3_tgt_valid_drop got %h exp 00", bus.tgt_valid); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd3_rsp_early got %b exp 0", bus.rsp_valid); end
    bus.tgt_rvalid = 8'h08;
    set_rdata(3, 32'hCAFE_0003);
    @(negedge clk);  // N+3
    bus.tgt_rvalid = '0;
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd3_rsp_valid got %b exp 1", bus.rsp_valid); end
    n_cmp++; if (bus.up_ready !== 1'b1) begin n_bad++; $display("FAIL rd3_up_ready_rsp got %b exp 1", bus.up_ready); end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rd3_rsp got %h exp %h", got, exp); end
    end else begin
      n_cmp++; n_bad++; $display("FAIL rd3_queue got empty exp entry");
    end
    @(negedge clk);  // N+4
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd3_rsp_pulse got %b exp 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rdata !== 32'hCAFE_0003) begin n_bad++; $display("FAIL rd3_rdata_hold got %h exp cafe0003", bus.rsp_rdata); end
  endtask

  task automatic test_write_stall;
    logic [32:0] got, exp;
    bit seen;
    send_req(32'hE000_0000, 1, 32'hA5A5_1234, 4'b0011, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.tgt_valid !== 8'h80) begin n_bad++; $display("FAIL wr7_tgt_valid[%0d] got %h exp 80", i, bus.tgt_valid); end
      n_cmp++; if (bus.tgt_wmask !== 4'b0011) begin n_bad++; $display("FAIL wr7_wmask[%0d] got %b exp 0011", i, bus.tgt_wmask); end
      n_cmp++; if ({bus.tgt_we, bus.tgt_wdata} !== {1'b1, 32'hA5A5_1234}) begin n_bad++; $display("FAIL wr7_wdata[%0d] got %b/%h exp 1/a5a51234", i, bus.tgt_we, bus.tgt_wdata); end
      @(negedge clk);
    end
    serve(7, 0, 0, 32'hDEAD_BEEF);
    wait_rsp(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL wr7_rsp_timeout got none exp rsp_valid"); end
    if (seen && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL wr7_rsp got %h exp %h", got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_unmapped;
    bus_um.up_valid = 1; bus_um.up_addr = 32'hF000_0000; bus_um.up_we = 0;
    @(negedge clk);  // N+1
    bus_um.up_valid = 0;
    n_cmp++; if (bus_um.tgt_valid !== 8'h00) begin n_bad++; $display("FAIL um_tgt_valid got %h exp 00", bus_um.tgt_valid); end
    n_cmp++; if (bus_um.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL um_rsp_early got %b exp 0", bus_um.rsp_valid); end
    @(negedge clk);  // N+2
    n_cmp++; if ({bus_um.rsp_valid, bus_um.rsp_err} !== 2'b11) begin n_bad++; $display("FAIL um_rsp_err got %b%b exp 11", bus_um.rsp_valid, bus_um.rsp_err); end
    n_cmp++; if (bus_um.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL um_rdata got %h exp 0", bus_um.rsp_rdata); end
    n_cmp++; if (bus_um.tgt_valid !== 8'h00) begin n_bad++; $display("FAIL um_tgt_valid2 got %h exp 00", bus_um.tgt_valid); end
    n_cmp++; if (bus_um.up_ready !== 1'b1) begin n_bad++; $display("FAIL um_up_ready got %b exp 1", bus_um.up_ready); end
    @(negedge clk);
  endtask

  task automatic test_stray;
    logic [32:0] got, exp;
    bit seen;
    send_req(32'hA000_0020, 0, 32'h0, 4'hF, 0, 32'h5555_0005, 1);
    bus.tgt_ready = 8'h04;      // other target's ready must not advance REQ
    bus.tgt_rvalid = 8'h04;
    set_rdata(2, 32'h1111_1111);
    @(negedge clk);
    n_cmp++; if (bus.tgt_valid !== 8'h20) begin n_bad++; $display("FAIL stray_ready_ignored got %h exp 20", bus.tgt_valid); end
    bus.tgt_ready = 8'h20;
    bus.tgt_rvalid = '0;
    @(negedge clk);
    bus.tgt_ready = '0;
    bus.tgt_rvalid = 8'h04;     // stray response while in RESP
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stray_rvalid_ignored got %b exp 0", bus.rsp_valid); end
    bus.tgt_rvalid = 8'h24;
    set_rdata(5, 32'h5555_0005);
    @(negedge clk);
    bus.tgt_rvalid = '0;
    wait_rsp(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL stray_rsp_timeout got none exp rsp_valid"); end
    if (seen && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL stray_rsp got %h exp %h", got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_resp;
    logic [32:0] got, exp;
    bit seen;
    send_req(32'h0000_0040, 0, 32'h0, 4'hF, 0, 32'h0, 0);
    bus.tgt_ready = 8'h01;
    @(negedge clk);
    bus.tgt_ready = '0;
    n_cmp++; if (dbg_state !== RESP) begin n_bad++; $display("FAIL rstresp_in_resp got %0d exp 2", dbg_state); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rstresp_state got %0d exp 0", dbg_state); end
    n_cmp++; if (bus.up_ready !== 1'b1) begin n_bad++; $display("FAIL rstresp_up_ready got %b exp 1", bus.up_ready); end
    bus.tgt_rvalid = 8'h01;
    set_rdata(0, 32'h7777_7777);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstresp_no_rsp[%0d] got %b exp 0", i, bus.rsp_valid); end
      @(negedge clk);
    end
    bus.tgt_rvalid = '0;
    send_req(32'h0000_0080, 0, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1);
    n_cmp++; if (bus.tgt_valid !== 8'h01) begin n_bad++; $display("FAIL rstresp_fresh_valid got %h exp 01", bus.tgt_valid); end
    serve(0, 1, 1, 32'h0BAD_F00D);
    wait_rsp(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstresp_fresh_timeout got none exp rsp_valid"); end
    if (seen && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rstresp_fresh_rsp got %h exp %h", got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [32:0] got, exp;
    bit seen;
    send_req(32'h2000_0004, 0, 32'h0, 4'hF, 0, 32'h0000_1001, 1);
    serve(1, 0, 0, 32'h0000_1001);
    n_cmp++; if ({bus.rsp_valid, bus.up_ready} !== 2'b11) begin n_bad++; $display("FAIL b2b_first_rsp got %b%b exp 11", bus.rsp_valid, bus.up_ready); end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_first got %h exp %h", got, exp); end
    end
    // Issue the next request in the response cycle itself.
    send_req(32'h8000_0008, 0, 32'h0, 4'hF, 0, 32'h0000_4004, 1);
    n_cmp++; if (bus.tgt_valid !== 8'h10) begin n_bad++; $display("FAIL b2b_second_valid got %h exp 10", bus.tgt_valid); end
    serve(4, 0, 2, 32'h0000_4004);
    wait_rsp(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_second_timeout got none exp rsp_valid"); end
    if (seen && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_second got %h exp %h", got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [32:0] got, exp;
    logic [31:0] addr, data;
    logic [2:0]  t;
    logic        we;
    bit seen;
    for (int i = 0; i < 24; i++) begin
      t    = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      addr = {t, 29'($urandom)};
      data = $urandom;
      send_req(addr, we, ~data, 4'($urandom_range(0, 15)), 0, we ? 32'h0 : data, 1);
      n_cmp++; if (bus.tgt_valid !== (8'h01 << t)) begin n_bad++; $display("FAIL rnd_valid[%0d] got %h exp %h", i, bus.tgt_valid, 8'h01 << t); end
      n_cmp++; if (bus.tgt_addr !== addr) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, bus.tgt_addr, addr); end
      serve(int'(t), $urandom_range(0, 3), $urandom_range(0, 3), data);
      wait_rsp(seen);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL rnd_timeout[%0d] got none exp rsp_valid", i); end
      if (seen && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {bus.rsp_err, bus.rsp_rdata};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rnd_rsp[%0d] got %h exp %h", i, got, exp); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
`ifdef ROUTER_TIMEOUT_EN
    logic [32:0] got, exp;
    bit seen;
    send_req(32'hC000_0000, 0, 32'h0, 4'hF, 1, 32'h0, 1);
    bus.tgt_ready = 8'h40;
    @(negedge clk);
    bus.tgt_ready = '0;
    // four empty RESP cycles, then the ERR cycle, then the response
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_early[%0d] got %b exp 0", i, bus.rsp_valid); end
      @(negedge clk);
    end
    wait_rsp(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL to_no_rsp got none exp rsp_valid"); end
    if (seen && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rsp_err, bus.rsp_rdata};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL to_rsp got %h exp %h", got, exp); end
    end
    @(negedge clk);
    bus.tgt_rvalid = 8'h40;
    set_rdata(6, 32'h6666_6666);
    @(negedge clk);
    bus.tgt_rvalid = '0;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_late_ignored got %b exp 0", bus.rsp_valid); end
    @(negedge clk);
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_t3();
    test_write_stall();
    test_unmapped();
    test_stray();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    test_timeout();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL queue_drained got %0d exp 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_router_1to8.md
Name: dmem_router_1to8

Overview:
- Single-initiator to eight-target data-memory request router for the RV32I pipeline's MEM stage.
- Decodes a 3-bit region select from the request address and forwards the request to exactly one target.
- Waits for that target's response and returns the response data to the core.
- This is the fan-out/request side of the 8-way result selection used at writeback: one request in, one of eight targets out, with one transaction outstanding at a time.

Parameters:
- SEL_LSB, 29: bit position of the 3-bit region select; sel = addr[SEL_LSB+2:SEL_LSB].
- MAP_MASK, 8'hFF: bit i = 1 means target i is populated; unpopulated regions return an error.
- TIMEOUT_CYCLES, 255: response-wait limit. Used only with ROUTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- up_valid  in  1  request valid from the core.
- up_ready  out  1  router can accept a request.
- up_addr  in  32  byte address.
- up_we  in  1  1 = write, 0 = read.
- up_wdata  in  32  write data.
- up_wmask  in  4  byte-enable mask.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  unmapped region or timeout.
- tgt_valid  out  8  one-hot request valid, one bit per target.
- tgt_ready  in  8  per-target accept.
- tgt_addr  out  32  shared, registered address.
- tgt_we  out  1  shared, registered write enable.
- tgt_wdata  out  32  shared, registered write data.
- tgt_wmask  out  4  shared, registered byte mask.
- tgt_rvalid  in  8  per-target response valid.
- tgt_rdata  in  256  flattened response data; target i occupies [32*i+31:32*i].

Behaviour:
- Reset (rst high at a clock edge): state = IDLE; tgt_valid = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; captured registers = 0. up_ready reads 1 after reset.
- Reset mid-transaction aborts the transaction: tgt_valid drops the cycle after the reset edge, and no response is ever issued for it.
- up_ready = (state == IDLE). It is combinational from the state register only.
- IDLE: on up_valid && up_ready, capture addr/we/wdata/wmask and sel.
  - If MAP_MASK[sel] = 1, go to REQ.
  - Otherwise go to ERR.
- REQ: tgt_valid[sel] = 1, all other bits 0. Shared tgt_* buses hold the captured values.
  - On tgt_ready[sel], go to RESP; tgt_valid drops next cycle.
  - tgt_ready bits of other targets are ignored.
- RESP: wait for tgt_rvalid[sel]. tgt_rvalid is sampled only in RESP; rvalid on any other target is ignored.
  - When it arrives: next cycle rsp_valid = 1 and rsp_err = 0.
  - rsp_rdata = tgt_rdata slice [sel] for reads, 0 for writes.
  - Then go to IDLE.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 for one cycle, then go to IDLE.
- rsp_valid is always a single-cycle pulse. rsp_rdata and rsp_err hold their values until the next response.
- Latency: accept at cycle N → tgt_valid at N+1. If tgt_ready is high at N+1 and tgt_rvalid is high at N+2, rsp_valid is at N+3. Unmapped region: rsp_valid at N+2.
- Back-to-back: up_ready returns high the cycle rsp_valid is high, so the next request is accepted in the response cycle.
- One outstanding transaction only; there is no buffering beyond the capture registers.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to RESP and increments each RESP cycle without tgt_rvalid[sel].
  - When the counter reaches TIMEOUT_CYCLES, go to ERR (rsp_err = 1, rsp_rdata = 0).
  - A late tgt_rvalid from the abandoned target is ignored.
- Undefined: RESP waits indefinitely, and no counter logic is synthesized.

Decomposition:
- Shared package (rv32i_bus_pkg):
  - State encoding IDLE=2'd0, REQ=2'd1, RESP=2'd2, ERR=2'd3.
  - NUM_TGT = 8.
  - SEL_W = 3.
- One sub-module: dmem_rsp_select, a combinational 8:1 slice of tgt_rdata/tgt_rvalid by sel, instantiated once.

Test Plan:
- Read target 3: up_addr=32'h6000_0010, we=0; tgt_ready[3] at N+1; tgt_rvalid[3] at N+2 with rdata 32'hCAFE_0003 → tgt_valid = 8'h08 at N+1; rsp_valid at N+3 with rsp_rdata = 32'hCAFE_0003 and rsp_err = 0.
- Write target 7 with stalls: up_addr=32'hE000_0000, wmask=4'b0011; tgt_ready[7] low for 4 cycles → tgt_valid = 8'h80 and tgt_wmask = 4'b0011 stay stable throughout; rsp_rdata = 0 on completion.
- Unmapped region: MAP_MASK=8'h7F, up_addr=32'hF000_0000 → no tgt_valid ever; rsp_valid and rsp_err = 1 at N+2.
- Stray response: tgt_rvalid[2] with rdata 32'h1111_1111 during a target-5 transaction → ignored; rsp_rdata comes from target 5.
- Reset while in RESP → state returns to IDLE; no rsp_valid; up_ready = 1; a fresh read to target 0 completes normally.
- Timeout, with ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=4: target never responds → rsp_err = 1 and rsp_rdata = 0 after 4 RESP cycles.
